// File: rtl/mem_write_buffer.sv
// rtl/mem_write_buffer.sv - store buffer between core data port and single-port ram
// Optional load forwarding from queued stores: define WBUF_FWD_EN.
module mem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic        cpu_sync,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_d_in,
  output logic [31:0] cpu_d_out,
  output logic        cpu_stall,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_d_in,
  input  logic [31:0] ram_d_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [29:0]   waddr_q [DEPTH];
  logic [31:0]   data_q  [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          empty;
  logic          hit;
  logic          hazard;
  logic          load_own;
  logic          drain;
  logic          enq;
  logic [PW-1:0] idx;
`ifdef WBUF_FWD_EN
  logic [31:0]   hit_data;
`endif

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Scan oldest to youngest so the last match wins; the draining head is still valid.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef WBUF_FWD_EN
    hit_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (waddr_q[idx] == cpu_addr[31:2])) begin
        hit = 1'b1;
`ifdef WBUF_FWD_EN
        hit_data = data_q[idx];
`endif
      end
    end
  end

`ifdef WBUF_FWD_EN
  assign hazard = 1'b0;
`else
  assign hazard = cpu_re & ~cpu_we & hit;
`endif

  assign cpu_stall = (cpu_we & full) | (cpu_sync & ~empty) | hazard;
  assign load_own  = cpu_re & ~cpu_stall;
  // Gated by rst so stores pending at reset never reach ram.
  assign drain     = ~rst & ~load_own & ~empty;
  assign enq       = ~rst & cpu_we & ~cpu_stall;

  assign ram_we   = drain;
  assign ram_addr = drain ? {waddr_q[head_q], 2'b00} : cpu_addr;
  assign ram_d_in = drain ? data_q[head_q] : 32'h0;

  always_comb begin
    cpu_d_out = ram_d_out;
    if (cpu_we && cpu_re) begin
      cpu_d_out = 32'h0;
    end
`ifdef WBUF_FWD_EN
    else if (hit) begin
      cpu_d_out = hit_data;
    end
`endif
  end

  assign head_d  = head_q + PW'(drain);
  assign tail_d  = tail_q + PW'(enq);
  assign count_d = count_q + CW'(enq) - CW'(drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      waddr_q[tail_q] <= cpu_addr[31:2];
      data_q[tail_q]  <= cpu_d_in;
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// tb/tb_mem_write_buffer.sv - directed self-checking bench for mem_write_buffer
module tb_mem_write_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b1;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic        cpu_sync = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_d_in = 32'h0;
  logic [31:0] cpu_d_out;
  logic        cpu_stall;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_d_in;
  logic [31:0] ram_d_out;

  logic [31:0] mem [256];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mem_write_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_sync  (cpu_sync),
    .cpu_addr  (cpu_addr),
    .cpu_d_in  (cpu_d_in),
    .cpu_d_out (cpu_d_out),
    .cpu_stall (cpu_stall),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_d_in  (ram_d_in),
    .ram_d_out (ram_d_out)
  );

  // Word-addressed async-read ram, preloaded with DEAD0000+index.
  assign ram_d_out = mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD_0000 + 32'(i);
    end else if (ram_we) begin
      mem[ram_addr[9:2]] <= ram_d_in;
    end
  end

  task automatic cyc(input logic we, input logic re, input logic sync,
                     input logic [31:0] addr, input logic [31:0] din);
    @(negedge clk);
    cpu_we   = we;
    cpu_re   = re;
    cpu_sync = sync;
    cpu_addr = addr;
    cpu_d_in = din;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    cyc(0, 0, 0, 32'h40, 0);
    cyc(0, 0, 0, 32'h40, 0);
    rst  = 1'b0;
    init = 1'b0;
    cyc(0, 0, 0, 32'h40, 0);
    check("rst_stall", 32'(cpu_stall), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_d_out", cpu_d_out, 32'hDEAD_0010);

    // store then immediate load of the same word
    cyc(1, 0, 0, 32'h40, 32'h1111_1111);
    check("t1_st_stall", 32'(cpu_stall), 0);
    check("t1_st_ram_we", 32'(ram_we), 0);
`ifdef WBUF_FWD_EN
    cyc(0, 1, 0, 32'h40, 0);
    check("t1_ld_stall", 32'(cpu_stall), 0);
    check("t1_ld_data", cpu_d_out, 32'h1111_1111);
    check("t1_ld_ram_we", 32'(ram_we), 0);
    cyc(0, 0, 0, 32'h40, 0);
    check("t1_drain_we", 32'(ram_we), 1);
    check("t1_drain_data", ram_d_in, 32'h1111_1111);
`else
    cyc(0, 1, 0, 32'h40, 0);
    check("t1_ld_stall", 32'(cpu_stall), 1);
    check("t1_ld_drain_we", 32'(ram_we), 1);
    check("t1_ld_drain_addr", ram_addr, 32'h40);
    cyc(0, 1, 0, 32'h40, 0);
    check("t1_ld2_stall", 32'(cpu_stall), 0);
    check("t1_ld2_data", cpu_d_out, 32'h1111_1111);
    check("t1_ld2_ram_we", 32'(ram_we), 0);
`endif
    cyc(0, 0, 0, 32'h40, 0);
    check("t1_idle_we", 32'(ram_we), 0);

    // back-to-back plain stores drain one behind
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 32'(4 * k), 32'h5000_0000 + 32'(k));
      check("t2_stall", 32'(cpu_stall), 0);
      if (k == 0) begin
        check("t2_we0", 32'(ram_we), 0);
      end else begin
        check("t2_we", 32'(ram_we), 1);
        check("t2_addr", ram_addr, 32'(4 * (k - 1)));
        check("t2_data", ram_d_in, 32'h5000_0000 + 32'(k - 1));
      end
    end
    cyc(0, 0, 0, 0, 0);
    check("t2_last_we", 32'(ram_we), 1);
    check("t2_last_addr", ram_addr, 32'h10);
    cyc(0, 0, 0, 0, 0);
    check("t2_empty_we", 32'(ram_we), 0);

    // fill with store+load (load holds the port), then a store hits full
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 32'h80 + 32'(4 * k), 32'h6000_0000 + 32'(k));
      check("full_fill_stall", 32'(cpu_stall), 0);
      check("full_fill_dout", cpu_d_out, 0);
      check("full_fill_we", 32'(ram_we), 0);
    end
    cyc(1, 0, 0, 32'h90, 32'h6000_0004);
    check("full_stall", 32'(cpu_stall), 1);
    check("full_drain_addr", ram_addr, 32'h80);
    check("full_drain_we", 32'(ram_we), 1);
    cyc(1, 0, 0, 32'h90, 32'h6000_0004);
    check("full_accept_stall", 32'(cpu_stall), 0);
    check("full_accept_addr", ram_addr, 32'h84);
    for (int k = 2; k < 5; k++) begin
      cyc(0, 0, 0, 0, 0);
      check("full_tail_we", 32'(ram_we), 1);
      check("full_tail_addr", ram_addr, 32'h80 + 32'(4 * k));
      check("full_tail_data", ram_d_in, 32'h6000_0000 + 32'(k));
    end
    cyc(0, 0, 0, 0, 0);
    check("full_done_we", 32'(ram_we), 0);
    check("full_mem", mem[8'h24], 32'h6000_0004);

    // two queued stores to one word, youngest wins
    cyc(1, 1, 0, 32'h20, 32'h0000_000A);
    cyc(1, 1, 0, 32'h20, 32'h0000_000B);
`ifdef WBUF_FWD_EN
    cyc(0, 1, 0, 32'h20, 0);
    check("t3_stall", 32'(cpu_stall), 0);
    check("t3_data", cpu_d_out, 32'hB);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
`else
    cyc(0, 1, 0, 32'h20, 0);
    check("t3_stall_a", 32'(cpu_stall), 1);
    check("t3_drain_a", ram_d_in, 32'hA);
    cyc(0, 1, 0, 32'h20, 0);
    check("t3_stall_b", 32'(cpu_stall), 1);
    check("t3_drain_b", ram_d_in, 32'hB);
    cyc(0, 1, 0, 32'h20, 0);
    check("t3_stall_done", 32'(cpu_stall), 0);
    check("t3_data", cpu_d_out, 32'hB);
`endif
    cyc(0, 0, 0, 0, 0);
    check("t3_idle_we", 32'(ram_we), 0);
    check("t3_mem", mem[8], 32'hB);

    // unrelated loads block draining
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 32'h30 + 32'(4 * k), 32'h7000_0000 + 32'(k));
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 32'h100, 0);
      check("t4_ld_we", 32'(ram_we), 0);
      check("t4_ld_stall", 32'(cpu_stall), 0);
      check("t4_ld_data", cpu_d_out, 32'hDEAD_0040);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0);
      check("t4_drain_we", 32'(ram_we), 1);
      check("t4_drain_addr", ram_addr, 32'h30 + 32'(4 * k));
    end
    cyc(0, 0, 0, 0, 0);
    check("t4_done_we", 32'(ram_we), 0);

    // sync stalls exactly while the queue drains
    cyc(1, 1, 0, 32'h50, 32'h8000_0000);
    cyc(1, 1, 0, 32'h54, 32'h8000_0001);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 1, 0, 0);
      check("t5_stall", 32'(cpu_stall), 1);
      check("t5_we", 32'(ram_we), 1);
    end
    cyc(0, 0, 1, 0, 0);
    check("t5_release", 32'(cpu_stall), 0);
    check("t5_done_we", 32'(ram_we), 0);
    check("t5_mem0", mem[8'h14], 32'h8000_0000);
    check("t5_mem1", mem[8'h15], 32'h8000_0001);

    // reset discards pending stores
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 32'h60 + 32'(4 * k), 32'h9000_0000 + 32'(k));
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("t6_rst_we", 32'(ram_we), 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    check("t6_after_we", 32'(ram_we), 0);
    check("t6_after_stall", 32'(cpu_stall), 0);
    for (int k = 0; k < 3; k++) check("t6_mem", mem[8'h18 + 8'(k)], 32'hDEAD_0018 + 32'(k));

    // offset pointers by one, then two full rounds to wrap
    cyc(1, 0, 0, 32'h9C, 32'hC000_0000);
    cyc(0, 0, 0, 0, 0);
    check("wrap_pre_addr", ram_addr, 32'h9C);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        cyc(1, 1, 0, 32'hA0 + 32'(16 * r + 4 * k), 32'hC100_0000 + 32'(16 * r + k));
      for (int k = 0; k < 4; k++) begin
        cyc(0, 0, 0, 0, 0);
        check("wrap_addr", ram_addr, 32'hA0 + 32'(16 * r + 4 * k));
        check("wrap_data", ram_d_in, 32'hC100_0000 + 32'(16 * r + k));
      end
      cyc(0, 0, 0, 0, 0);
      check("wrap_empty_we", 32'(ram_we), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
